// File: rtl/mul_booth_seq.sv
// rtl/mul_booth_seq.sv - iterative radix-4 Booth multiplier, signed/unsigned per transaction
// One Booth digit per clock; the multiplicand shifts left and the multiplier right by two each step.
module mul_booth_seq #(
   parameter int A_W = 16,
   parameter int B_W = 16
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic [A_W-1:0]     a,
   input  logic [B_W-1:0]     b,
   input  logic               tc,
   output logic               out_valid,
   input  logic               out_ready,
   output logic [A_W+B_W-1:0] product
);

   localparam int EB    = ((B_W + 1) % 2 == 0) ? (B_W + 1) : (B_W + 2);
   localparam int N     = EB / 2;
   localparam int ACC_W = A_W + EB + 2;
   localparam int CW    = $clog2(N + 1);
   localparam int P_W   = A_W + B_W;

   typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

   state_t           state_q, state_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic [ACC_W-1:0] acc_q, acc_d;
   logic [ACC_W-1:0] m_q, m_d;
   logic [EB:0]      b_q, b_d;
   logic [P_W-1:0]   product_q, product_d;
   logic             out_valid_q, out_valid_d;
   logic [ACC_W-1:0] addend;

   // b_q[2:0] always holds bits {2i+1, 2i, 2i-1} of the extended multiplier
   always_comb begin
      addend = '0;
      unique case (b_q[2:0])
         3'b001, 3'b010: addend = m_q;
         3'b011:         addend = m_q << 1;
         3'b100:         addend = -(m_q << 1);
         3'b101, 3'b110: addend = -m_q;
         default:        addend = '0;
      endcase
   end

   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      acc_d       = acc_q;
      m_d         = m_q;
      b_d         = b_q;
      product_d   = product_q;
      out_valid_d = out_valid_q;
      unique case (state_q)
         IDLE: begin
            if (in_valid) begin
               // Zero-extension keeps the top bit of b clear, so unsigned values recode as positive
               m_d     = {{(ACC_W - A_W){tc & a[A_W-1]}}, a};
               b_d     = {{(EB - B_W){tc & b[B_W-1]}}, b, 1'b0};
               acc_d   = '0;
               cnt_d   = '0;
               state_d = CALC;
            end
         end
         CALC: begin
            acc_d = acc_q + addend;
            m_d   = m_q << 2;
            b_d   = b_q >> 2;
            cnt_d = cnt_q + CW'(1);
            if (cnt_q == CW'(N - 1)) begin
               product_d   = acc_d[P_W-1:0];
               out_valid_d = 1'b1;
               state_d     = DONE;
            end
         end
         DONE: begin
            if (out_ready) begin
               out_valid_d = 1'b0;
               state_d     = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         cnt_q       <= '0;
         acc_q       <= '0;
         m_q         <= '0;
         b_q         <= '0;
         product_q   <= '0;
         out_valid_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         acc_q       <= acc_d;
         m_q         <= m_d;
         b_q         <= b_d;
         product_q   <= product_d;
         out_valid_q <= out_valid_d;
      end
   end

   assign in_ready  = (state_q == IDLE);
   assign out_valid = out_valid_q;
   assign product   = product_q;

endmodule

// File: tb/tb_mul_booth_seq.sv
// tb/tb_mul_booth_seq.sv - directed and random checks of mul_booth_seq at 16x16 and 12x7
module tb_mul_booth_seq;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        out_ready = 1'b0;
   logic        iv1 = 1'b0, tc1 = 1'b0, ir1, ov1;
   logic [15:0] a1 = '0, b1 = '0;
   logic [31:0] p1;
   logic        iv2 = 1'b0, tc2 = 1'b0, ir2, ov2;
   logic [11:0] a2 = '0;
   logic [6:0]  b2 = '0;
   logic [18:0] p2;
   logic        sel_m = 1'b0;
   logic        ov_m, ir_m;
   logic [31:0] pr_m;
   int          n_checks = 0;
   int          n_fail = 0;

   always #5 clk = ~clk;

   mul_booth_seq #(.A_W(16), .B_W(16)) u_dut16 (
      .clk(clk), .rst_n(rst_n), .in_valid(iv1), .in_ready(ir1), .a(a1), .b(b1), .tc(tc1),
      .out_valid(ov1), .out_ready(out_ready), .product(p1));

   mul_booth_seq #(.A_W(12), .B_W(7)) u_dut12x7 (
      .clk(clk), .rst_n(rst_n), .in_valid(iv2), .in_ready(ir2), .a(a2), .b(b2), .tc(tc2),
      .out_valid(ov2), .out_ready(out_ready), .product(p2));

   assign ov_m = sel_m ? ov2 : ov1;
   assign ir_m = sel_m ? ir2 : ir1;
   assign pr_m = sel_m ? {13'b0, p2} : p1;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic logic [31:0] ref_prod(input bit s, input logic [15:0] av, input logic [15:0] bv,
                                             input logic tcv);
      int aw, bw;
      longint x, y, p;
      aw = s ? 12 : 16;
      bw = s ? 7 : 16;
      x = longint'(av) & ((longint'(1) << aw) - 1);
      y = longint'(bv) & ((longint'(1) << bw) - 1);
      if (tcv && x[aw-1]) x = x - (longint'(1) << aw);
      if (tcv && y[bw-1]) y = y - (longint'(1) << bw);
      p = x * y;
      return 32'(p & ((longint'(1) << (aw + bw)) - 1));
   endfunction

   task automatic drive(input bit s, input logic [15:0] av, input logic [15:0] bv, input logic tcv,
                        input logic v);
      if (s) begin
         a2 = av[11:0]; b2 = bv[6:0]; tc2 = tcv; iv2 = v;
      end else begin
         a1 = av; b1 = bv; tc1 = tcv; iv1 = v;
      end
   endtask

   task automatic txn(input bit s, input logic [15:0] av, input logic [15:0] bv, input logic tcv,
                      input logic [31:0] ev, input int stall, input string tag);
      int lat;
      sel_m = s;
      #1;
      chk({tag, " in_ready"}, ir_m, 1);
      drive(s, av, bv, tcv, 1'b1);
      @(posedge clk); #1;
      drive(s, 16'($urandom), 16'($urandom), 1'($urandom), 1'b0);
      lat = 0;
      while (!ov_m && lat < 40) begin
         @(posedge clk); #1;
         lat++;
      end
      chk({tag, " latency"}, lat, s ? 4 : 9);
      chk({tag, " product"}, pr_m, ev);
      repeat (stall) begin
         drive(s, 16'($urandom), 16'($urandom), 1'($urandom), 1'b1);
         @(posedge clk); #1;
         chk({tag, " stall out_valid"}, ov_m, 1);
         chk({tag, " stall product"}, pr_m, ev);
         chk({tag, " stall in_ready"}, ir_m, 0);
      end
      drive(s, 16'($urandom), 16'($urandom), 1'($urandom), 1'b0);
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
      chk({tag, " out_valid drop"}, ov_m, 0);
      chk({tag, " in_ready back"}, ir_m, 1);
      chk({tag, " product held"}, pr_m, ev);
   endtask

   initial begin
      logic [15:0] av, bv;
      logic        t;
      bit          seen;

      #12;
      chk("rst out_valid", ov1, 0);
      chk("rst product", p1, 0);
      chk("rst in_ready", ir1, 1);
      rst_n = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      chk("idle in_ready", ir1, 1);
      chk("idle out_valid", ov1, 0);

      txn(0, 16'h8000, 16'h8000, 1'b1, 32'h4000_0000, 0, "s_minmin");
      txn(0, 16'hFFFF, 16'hFFFF, 1'b1, 32'h0000_0001, 0, "s_m1m1");
      txn(0, 16'h7FFF, 16'h8000, 1'b1, 32'hC000_8000, 1, "s_maxmin");
      txn(0, 16'hFFFF, 16'hFFFF, 1'b0, 32'hFFFE_0001, 0, "u_maxmax");
      txn(0, 16'h8000, 16'h0002, 1'b0, 32'h0001_0000, 0, "u_8000x2");
      txn(0, 16'h8000, 16'h0002, 1'b1, 32'hFFFF_0000, 0, "s_8000x2");
      txn(0, 16'h0000, 16'h1234, 1'b1, 32'h0000_0000, 0, "zero");
      txn(0, 16'd100, 16'hFFFD, 1'b1, 32'hFFFF_FED4, 20, "backpressure");

      sel_m = 1'b0;
      drive(0, 16'd1234, 16'd5678, 1'b0, 1'b1);
      @(posedge clk); #1;
      drive(0, 16'd0, 16'd0, 1'b0, 1'b0);
      repeat (4) @(posedge clk);
      #1;
      rst_n = 1'b0;
      #1;
      chk("midrst out_valid", ov1, 0);
      chk("midrst product", p1, 0);
      chk("midrst in_ready", ir1, 1);
      @(posedge clk); #1;
      rst_n = 1'b1;
      seen = 1'b0;
      repeat (12) begin
         @(posedge clk); #1;
         if (ov1) seen = 1'b1;
      end
      chk("midrst no stale", seen, 0);
      txn(0, 16'd3, 16'd5, 1'b0, 32'd15, 0, "after_rst");

      txn(1, 16'h0800, 16'h0040, 1'b1, 32'h0002_0000, 0, "n_minmin");
      txn(1, 16'h0FFF, 16'h007F, 1'b0, 32'h0007_EF81, 2, "n_umax");

      for (int i = 0; i < 300; i++) begin
         av = 16'($urandom); bv = 16'($urandom); t = 1'($urandom);
         txn(0, av, bv, t, ref_prod(0, av, bv, t), $urandom_range(0, 3), "rnd16");
      end
      for (int i = 0; i < 300; i++) begin
         av = 16'($urandom); bv = 16'($urandom); t = 1'($urandom);
         txn(1, av, bv, t, ref_prod(1, av, bv, t), $urandom_range(0, 3), "rnd12x7");
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
